// File: rtl/nettlp_rx_filter.sv
// nettlp_rx_filter: strips Ethernet/IPv4/UDP/NetTLP headers (48 bytes, beats
// 0-5) from a 64-bit MAC receive stream and forwards the TLP payload of
// frames addressed to the local MAC/IP/UDP port.
// Optional frame statistics: define NETTLP_RX_FILTER_STATS_EN.
module nettlp_rx_filter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 eth_clk,
  input  logic                 eth_rst_n,
  input  logic                 eth_rx_tvalid,
  input  logic [63:0]          eth_rx_tdata,
  input  logic [7:0]           eth_rx_tkeep,
  input  logic                 eth_rx_tlast,
  input  logic                 eth_rx_tuser,
  input  logic [47:0]          adapter_reg_srcmac,
  input  logic [31:0]          adapter_reg_srcip,
  input  logic [15:0]          adapter_reg_srcport,
  output logic                 tlp_rx_tvalid,
  output logic [63:0]          tlp_rx_tdata,
  output logic [7:0]           tlp_rx_tkeep,
  output logic                 tlp_rx_tlast,
  output logic                 tlp_rx_tuser,
  output logic [15:0]          nettlp_seq,
  output logic [31:0]          nettlp_tstamp,
  output logic [CNT_WIDTH-1:0] cnt_accept,
  output logic [CNT_WIDTH-1:0] cnt_drop
);

  typedef enum logic [1:0] {HDR, FWD, DROP} state_t;

  state_t      state, state_nx;
  logic [2:0]  cnt, cnt_nx;
  logic        hdr_ok, fwd, acc_inc, drp_inc;
  logic        first_q;
  logic [47:0] mac_q;
  logic [31:0] ip_q;
  logic [15:0] port_q;
  logic [15:0] seq_pend;
  logic [31:0] tstamp_pend;
  logic [1:0]  rst_sync;
  logic        rst_n;

  // Reset: asserts immediately, releases two eth_clk edges later
  always_ff @(posedge eth_clk or negedge eth_rst_n) begin
    if (!eth_rst_n) rst_sync <= 2'b00;
    else            rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // Per-beat header check; byte n of a beat sits in tdata[8n+7:8n]
  always_comb begin
    hdr_ok = 1'b1;
    case (cnt)
      3'd0: hdr_ok = (eth_rx_tdata[47:0] ==
                      {adapter_reg_srcmac[7:0],   adapter_reg_srcmac[15:8],
                       adapter_reg_srcmac[23:16], adapter_reg_srcmac[31:24],
                       adapter_reg_srcmac[39:32], adapter_reg_srcmac[47:40]});
      3'd1: hdr_ok = (eth_rx_tdata[55:32] == {8'h45, 8'h00, 8'h08});
      3'd2: hdr_ok = (eth_rx_tdata[63:56] == 8'h11);
      3'd3: hdr_ok = (eth_rx_tdata[63:48] == {ip_q[23:16], ip_q[31:24]});
      3'd4: hdr_ok = (eth_rx_tdata[15:0]  == {ip_q[7:0], ip_q[15:8]}) &&
                     (eth_rx_tdata[47:32] == {port_q[7:0], port_q[15:8]});
      default: hdr_ok = 1'b1;
    endcase
  end

  // Next-state, beat counter and per-beat forward/count strobes
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    fwd      = 1'b0;
    acc_inc  = 1'b0;
    drp_inc  = 1'b0;
    if (eth_rx_tvalid) begin
      case (state)
        HDR: begin
          if (eth_rx_tlast) begin
            // runt, header-only or rejected-on-last-beat frame
            state_nx = HDR;
            cnt_nx   = 3'd0;
            drp_inc  = 1'b1;
          end else if (!hdr_ok) begin
            state_nx = DROP;
            cnt_nx   = 3'd0;
          end else if (cnt == 3'd5) begin
            state_nx = FWD;
            cnt_nx   = 3'd0;
          end else begin
            cnt_nx = cnt + 3'd1;
          end
        end
        FWD: begin
          fwd = 1'b1;
          if (eth_rx_tlast) begin
            state_nx = HDR;
            acc_inc  = ~eth_rx_tuser;
            drp_inc  = eth_rx_tuser;
          end
        end
        default: begin
          if (eth_rx_tlast) begin
            state_nx = HDR;
            drp_inc  = 1'b1;
          end
        end
      endcase
    end
  end

  // State register and beat counter
  always_ff @(posedge eth_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HDR;
      cnt   <= 3'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Sample local addresses at beat 0; capture NetTLP fields at beat 5
  always_ff @(posedge eth_clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_q       <= '0;
      ip_q        <= '0;
      port_q      <= '0;
      seq_pend    <= '0;
      tstamp_pend <= '0;
      first_q     <= 1'b0;
    end else begin
      if (eth_rx_tvalid && state == HDR && cnt == 3'd0) begin
        mac_q  <= adapter_reg_srcmac;
        ip_q   <= adapter_reg_srcip;
        port_q <= adapter_reg_srcport;
      end
      if (eth_rx_tvalid && state == HDR && cnt == 3'd5) begin
        seq_pend    <= {eth_rx_tdata[23:16], eth_rx_tdata[31:24]};
        tstamp_pend <= {eth_rx_tdata[39:32], eth_rx_tdata[47:40],
                        eth_rx_tdata[55:48], eth_rx_tdata[63:56]};
      end
      if (state == HDR && state_nx == FWD) first_q <= 1'b1;
      else if (fwd)                         first_q <= 1'b0;
    end
  end

  // Registered TLP output; NetTLP fields switch with the first payload beat
  always_ff @(posedge eth_clk or negedge rst_n) begin
    if (!rst_n) begin
      tlp_rx_tvalid <= 1'b0;
      tlp_rx_tdata  <= '0;
      tlp_rx_tkeep  <= '0;
      tlp_rx_tlast  <= 1'b0;
      tlp_rx_tuser  <= 1'b0;
      nettlp_seq    <= '0;
      nettlp_tstamp <= '0;
    end else begin
      tlp_rx_tvalid <= fwd;
      tlp_rx_tlast  <= fwd & eth_rx_tlast;
      tlp_rx_tuser  <= fwd & eth_rx_tuser;
      if (fwd) begin
        tlp_rx_tdata <= eth_rx_tdata;
        tlp_rx_tkeep <= eth_rx_tkeep;
      end
      if (fwd && first_q) begin
        nettlp_seq    <= seq_pend;
        nettlp_tstamp <= tstamp_pend;
      end
    end
  end

`ifdef NETTLP_RX_FILTER_STATS_EN
  // Saturating frame counters
  always_ff @(posedge eth_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_accept <= '0;
      cnt_drop   <= '0;
    end else begin
      if (acc_inc && cnt_accept != '1) cnt_accept <= cnt_accept + 1'b1;
      if (drp_inc && cnt_drop   != '1) cnt_drop   <= cnt_drop + 1'b1;
    end
  end
`else
  logic unused_cnt;
  assign unused_cnt = acc_inc ^ drp_inc;
  assign cnt_accept = '0;
  assign cnt_drop   = '0;
`endif

endmodule
